// File: rtl/control_busqueda_if.sv
// Debug read port into the shared instruction memory.
// The requester holds dbg_req until it sees the dbg_ack pulse.
interface control_busqueda_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output dbg_req,
        output dbg_addr,
        input  dbg_ack,
        input  dbg_data
    );

    modport slave (
        input  dbg_req,
        input  dbg_addr,
        output dbg_ack,
        output dbg_data
    );
endinterface

// File: rtl/control_busqueda.sv
// Instruction-fetch sequencer: PC, stall/branch/halt, debug reads while halted.
// Optional fetch breakpoint when FETCH_BREAKPOINT_EN is defined.
module control_busqueda #(
    parameter int              ADDR_W   = 6,
    parameter int              DATA_W   = 32,
    parameter logic [5:0]      HALT_OP  = 6'h3F,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_take,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    input  logic              resume,
    input  logic [DATA_W-1:0] instru,
    output logic [ADDR_W-1:0] direinstru,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instru_valid,
    output logic              halted,
`ifdef FETCH_BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
`endif
    control_busqueda_if.slave dbg
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] HALT    = 2'd1;
    localparam logic [1:0] DBG     = 2'd2;
    localparam logic [1:0] DBG_ACK = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              halt_op;
    logic              bp_hit;

    assign halt_op = (instru[DATA_W-1 -: 6] == HALT_OP);

`ifdef FETCH_BREAKPOINT_EN
    // Masked on the first RUN cycle after resume so a step can leave the bp.
    logic bp_mask;

    assign bp_hit = bp_en & (pc == bp_addr) & ~bp_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bp_mask <= 1'b0;
        end else if (state == RUN) begin
            bp_mask <= 1'b0;
        end else if (state == HALT && !dbg.dbg_req && resume) begin
            bp_mask <= 1'b1;
        end
    end
`else
    assign bp_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            pc           <= RESET_PC;
            dbg.dbg_ack  <= 1'b0;
            dbg.dbg_data <= '0;
        end else begin
            dbg.dbg_ack <= 1'b0;
            unique case (state)
                RUN: begin
                    if (halt_req || bp_hit) begin
                        state <= HALT;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (halt_op) begin
                        state <= HALT;
                    end else if (branch_take) begin
                        pc <= branch_target;
                    end else begin
                        pc <= pc + ADDR_W'(1);
                    end
                end
                HALT: begin
                    if (dbg.dbg_req) begin
                        state <= DBG;
                    end else if (resume) begin
                        state <= RUN;
                    end
                end
                DBG: begin
                    dbg.dbg_data <= instru;
                    dbg.dbg_ack  <= 1'b1;
                    state        <= DBG_ACK;
                end
                DBG_ACK: begin
                    state <= dbg.dbg_req ? DBG : HALT;
                end
                default: state <= RUN;
            endcase
        end
    end

    // dbg_addr only reaches the memory while a debug read is in flight.
    assign direinstru   = (state == DBG) ? dbg.dbg_addr : pc;
    assign pc_out       = pc;
    assign halted       = (state != RUN);
    assign instru_valid = (state == RUN) & ~stall & ~halt_req
                        & ~bp_hit & ~halt_op;

endmodule

// File: tb/tb_control_busqueda.sv
// Directed bench for control_busqueda: vector table plus multi-cycle sequences.
// Breakpoint sequence runs when FETCH_BREAKPOINT_EN is defined.
module tb_control_busqueda;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              stall;
    logic              branch_take;
    logic [ADDR_W-1:0] branch_target;
    logic              halt_req;
    logic              resume;
    logic [DATA_W-1:0] instru;
    logic [ADDR_W-1:0] direinstru;
    logic [ADDR_W-1:0] pc_out;
    logic              instru_valid;
    logic              halted;
`ifdef FETCH_BREAKPOINT_EN
    logic              bp_en;
    logic [ADDR_W-1:0] bp_addr;
`endif

    logic [DATA_W-1:0] mem [64];

    control_busqueda_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg ();

    control_busqueda dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_take   (branch_take),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .instru        (instru),
        .direinstru    (direinstru),
        .pc_out        (pc_out),
        .instru_valid  (instru_valid),
        .halted        (halted),
`ifdef FETCH_BREAKPOINT_EN
        .bp_en         (bp_en),
        .bp_addr       (bp_addr),
`endif
        .dbg           (dbg.slave)
    );

    always #5 clk = ~clk;

    assign instru = mem[direinstru];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall         = 1'b0;
        branch_take   = 1'b0;
        branch_target = '0;
        halt_req      = 1'b0;
        resume        = 1'b0;
    endtask

    typedef struct {
        logic       st;
        logic       br;
        logic [5:0] tgt;
        logic       hr;
        logic       rs;
        logic       e_valid;
        logic [5:0] e_pc;
        logic       e_halted;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{0, 1, 6'd5,  0, 0, 1, 6'd5,  0};
        tbl[1]  = '{1, 0, 6'd0,  0, 0, 0, 6'd5,  0};
        tbl[2]  = '{1, 0, 6'd0,  0, 0, 0, 6'd5,  0};
        tbl[3]  = '{0, 1, 6'd20, 0, 0, 1, 6'd20, 0};
        tbl[4]  = '{0, 0, 6'd0,  0, 0, 1, 6'd21, 0};
        tbl[5]  = '{1, 1, 6'd9,  1, 0, 0, 6'd21, 1};
        tbl[6]  = '{1, 1, 6'd9,  0, 0, 0, 6'd21, 1};
        tbl[7]  = '{0, 0, 6'd0,  0, 1, 0, 6'd21, 0};
        tbl[8]  = '{0, 0, 6'd0,  0, 0, 1, 6'd22, 0};
        tbl[9]  = '{0, 0, 6'd0,  1, 0, 0, 6'd22, 1};
        tbl[10] = '{0, 0, 6'd0,  0, 1, 0, 6'd22, 0};
        tbl[11] = '{0, 1, 6'd62, 0, 0, 1, 6'd62, 0};
        tbl[12] = '{0, 0, 6'd0,  0, 0, 1, 6'd63, 0};
        tbl[13] = '{0, 0, 6'd0,  0, 0, 1, 6'd0,  0};

        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        idle();
        dbg.dbg_req  = 1'b0;
        dbg.dbg_addr = '0;
`ifdef FETCH_BREAKPOINT_EN
        bp_en   = 1'b0;
        bp_addr = '0;
`endif

        // reset state
        reset_n = 1'b0;
        step();
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_addr", 32'(direinstru), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_ack", 32'(dbg.dbg_ack), 0);
        chk("rst_data", dbg.dbg_data, 0);
        reset_n = 1'b1;

        // sequential fetch with wrap
        for (int i = 0; i <= 64; i++) begin
            chk("seq_addr", 32'(direinstru), 32'(i % 64));
            chk("seq_valid", 32'(instru_valid), 1);
            if (i < 64) step();
        end

        // vector table
        for (int i = 0; i < 14; i++) begin
            stall         = tbl[i].st;
            branch_take   = tbl[i].br;
            branch_target = tbl[i].tgt;
            halt_req      = tbl[i].hr;
            resume        = tbl[i].rs;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(instru_valid),
                32'(tbl[i].e_valid));
            step();
            chk($sformatf("v%0d_pc", i), 32'(pc_out), 32'(tbl[i].e_pc));
            chk($sformatf("v%0d_halted", i), 32'(halted),
                32'(tbl[i].e_halted));
        end
        idle();

        // halt opcode at word 3
        mem[3] = 32'hFC00_0000;
        step(); step(); step();
        chk("hop_pc", 32'(pc_out), 3);
        chk("hop_valid", 32'(instru_valid), 0);
        chk("hop_run", 32'(halted), 0);
        step();
        chk("hop_halted", 32'(halted), 1);
        chk("hop_pc_hold", 32'(pc_out), 3);
        step();
        chk("hop_still", 32'(pc_out), 3);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("hop_resume", 32'(halted), 0);
        chk("hop_readdr", 32'(direinstru), 3);
        step();
        chk("hop_rehalt", 32'(halted), 1);

        // debug read, single
        dbg.dbg_req  = 1'b1;
        dbg.dbg_addr = 6'd2;
        resume       = 1'b1;
        #1;
        chk("dbg_pre_addr", 32'(direinstru), 3);
        step();
        resume = 1'b0;
        chk("dbg_addr", 32'(direinstru), 2);
        chk("dbg_noack", 32'(dbg.dbg_ack), 0);
        step();
        chk("dbg_ack", 32'(dbg.dbg_ack), 1);
        chk("dbg_data", dbg.dbg_data, 32'h1000_0002);
        dbg.dbg_req = 1'b0;
        step();
        chk("dbg_ack_drop", 32'(dbg.dbg_ack), 0);
        chk("dbg_halted", 32'(halted), 1);
        chk("dbg_pc", 32'(pc_out), 3);
        chk("dbg_back_addr", 32'(direinstru), 3);

        // back-to-back debug reads
        dbg.dbg_req  = 1'b1;
        dbg.dbg_addr = 6'd7;
        step(); step();
        chk("bb_data0", dbg.dbg_data, 32'h1000_0007);
        dbg.dbg_addr = 6'd9;
        step();
        chk("bb_ack_gap", 32'(dbg.dbg_ack), 0);
        chk("bb_addr1", 32'(direinstru), 9);
        step();
        chk("bb_ack1", 32'(dbg.dbg_ack), 1);
        chk("bb_data1", dbg.dbg_data, 32'h1000_0009);
        dbg.dbg_req = 1'b0;
        step();

        // reset during DBG aborts the read
        dbg.dbg_req  = 1'b1;
        dbg.dbg_addr = 6'd5;
        step();
        chk("rd_in_dbg", 32'(direinstru), 5);
        reset_n = 1'b0;
        #1;
        chk("rd_pc", 32'(pc_out), 0);
        chk("rd_halted", 32'(halted), 0);
        step();
        chk("rd_noack", 32'(dbg.dbg_ack), 0);
        dbg.dbg_req = 1'b0;
        reset_n     = 1'b1;
        mem[3]      = 32'h1000_0003;

`ifdef FETCH_BREAKPOINT_EN
        bp_en   = 1'b1;
        bp_addr = 6'd4;
        step(); step(); step(); step();
        chk("bp_pc", 32'(pc_out), 4);
        chk("bp_valid", 32'(instru_valid), 0);
        step();
        chk("bp_halted", 32'(halted), 1);
        chk("bp_pc_hold", 32'(pc_out), 4);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("bp_res_pc", 32'(pc_out), 4);
        chk("bp_res_valid", 32'(instru_valid), 1);
        step();
        chk("bp_pc5", 32'(pc_out), 5);
        chk("bp_run5", 32'(halted), 0);
        step();
        chk("bp_pc6", 32'(pc_out), 6);
        chk("bp_run6", 32'(halted), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
